// File: rtl/zombie_pkg.sv
// rtl/zombie_pkg.sv - shared widths and hit codes for the zombie-punch button front-end
package zombie_pkg;

  localparam int N_BTN_MAX = 3;
  localparam int HIT_ID_W  = 2;

  typedef logic [HIT_ID_W-1:0] hit_id_t;

  localparam hit_id_t HIT_NONE = 2'd0;
  localparam hit_id_t HIT_BTN0 = 2'd1;
  localparam hit_id_t HIT_BTN1 = 2'd2;
  localparam hit_id_t HIT_BTN2 = 2'd3;

  // Channel index to hit code; code 0 is reserved for "no hit".
  function automatic hit_id_t hit_code(input int idx);
    return hit_id_t'(idx + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: 2-flop sync, debounce counter, stable level, press pulse
module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Synchronise raw, then accept a new level only after it has differed from the
  // stable value for DEBOUNCE_CYCLES consecutive cycles; any return clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TERM) begin
        level <= s2;
        cnt   <= '0;
        press <= s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - debounced button levels, press pulses and a 1-entry hit event buffer
module btn_conditioner
  import zombie_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BTN-1:0]    btn_raw,
  output logic [N_BTN-1:0]    btn_level,
  output logic [N_BTN-1:0]    btn_press,
  output logic                hit_valid,
  output logic [HIT_ID_W-1:0] hit_id,
  input  logic                hit_ready,
  output logic                hit_drop
);

  hit_id_t win_id;
  logic    any_press;
  logic    losers;
  logic    load_ok;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  // Lowest-index press wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    win_id = HIT_NONE;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (btn_press[i]) win_id = hit_code(i);
    end
  end

  // Clearing the lowest set bit leaves exactly the presses that lost priority.
  assign any_press = |btn_press;
  assign losers    = |(btn_press & (btn_press - N_BTN'(1)));
  assign load_ok   = !hit_valid || hit_ready;

  // Single-entry hit buffer: load on press when free or draining, clear on accept, flag drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_valid <= 1'b0;
      hit_id    <= HIT_NONE;
      hit_drop  <= 1'b0;
    end else begin
      if (any_press && load_ok) begin
        hit_valid <= 1'b1;
        hit_id    <= win_id;
        hit_drop  <= losers;
      end else begin
        if (hit_valid && hit_ready) begin
          hit_valid <= 1'b0;
          hit_id    <= HIT_NONE;
        end
        hit_drop <= any_press;
      end
    end
  end

endmodule
